// File: rtl/mem_bus_stall_master_if.sv
// Wishbone classic bus bundle between the MEM-stage load/store master and its slave.
// Signal names keep the master's point of view (_o driven by master, _i driven by slave).
interface mem_bus_stall_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned SEL_W = DATA_W / 8;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/mem_bus_stall_master.sv
// MEM-stage load/store bus master: turns a one-cycle request into a Wishbone classic
// cycle and holds the pipeline stalled until it completes. Optional abort counter: MEM_TIMEOUT_EN.
module mem_bus_stall_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     mem_wdata_i,
  input  logic [DATA_W/8-1:0]   mem_sel_i,
  output logic                  stallreq_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  rdata_valid_o,
  output logic                  access_fault_o,
  mem_bus_stall_master_if.master wb
);

  localparam int unsigned SEL_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state, state_nxt;
  logic              cyc_nxt, stb_nxt, we_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [DATA_W-1:0] dat_nxt;
  logic [SEL_W-1:0]  sel_nxt;
  logic [DATA_W-1:0] rdata_nxt;
  logic              valid_nxt, fault_nxt;
  logic              timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Counts BUS cycles that ended without ack/err; the TIMEOUT-th such cycle aborts.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
`else
  // No abort path in this build; the parameter only matters with the counter enabled.
  assign timeout_hit = (TIMEOUT == 32'd0) & 1'b0;
`endif

  // Freeze the pipeline in the very cycle a request shows up, and throughout the bus cycle.
  assign stallreq_o = ((state == ST_IDLE) && mem_req_i) || (state == ST_BUS);

  // Next-state and next registered-output logic.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = wb.wb_cyc_o;
    stb_nxt   = wb.wb_stb_o;
    we_nxt    = wb.wb_we_o;
    adr_nxt   = wb.wb_adr_o;
    dat_nxt   = wb.wb_dat_o;
    sel_nxt   = wb.wb_sel_o;
    rdata_nxt = rdata_o;
    valid_nxt = 1'b0;
    fault_nxt = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_nxt   = cnt;
`endif

    case (state)
      ST_IDLE: begin
        if (mem_req_i) begin
          cyc_nxt   = 1'b1;
          stb_nxt   = 1'b1;
          we_nxt    = mem_we_i;
          adr_nxt   = mem_addr_i;
          dat_nxt   = mem_wdata_i;
          sel_nxt   = mem_sel_i;
          state_nxt = ST_BUS;
`ifdef MEM_TIMEOUT_EN
          cnt_nxt   = '0;
`endif
        end
      end

      ST_BUS: begin
        // Error wins over a simultaneous ack; timeout behaves exactly like an error.
        if (wb.wb_err_i || (!wb.wb_ack_i && timeout_hit)) begin
          cyc_nxt   = 1'b0;
          stb_nxt   = 1'b0;
          valid_nxt = 1'b1;
          fault_nxt = 1'b1;
          state_nxt = ST_DONE;
        end else if (wb.wb_ack_i) begin
          cyc_nxt   = 1'b0;
          stb_nxt   = 1'b0;
          valid_nxt = 1'b1;
          if (!wb.wb_we_o) begin
            rdata_nxt = wb.wb_dat_i;
          end
          state_nxt = ST_DONE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          cnt_nxt = cnt + CNT_W'(1);
`endif
        end
      end

      // One release cycle; the still-present request belongs to the departing instruction.
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        cyc_nxt   = 1'b0;
        stb_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      wb.wb_cyc_o    <= 1'b0;
      wb.wb_stb_o    <= 1'b0;
      wb.wb_we_o     <= 1'b0;
      wb.wb_adr_o    <= '0;
      wb.wb_dat_o    <= '0;
      wb.wb_sel_o    <= '0;
      rdata_o        <= '0;
      rdata_valid_o  <= 1'b0;
      access_fault_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      wb.wb_cyc_o    <= cyc_nxt;
      wb.wb_stb_o    <= stb_nxt;
      wb.wb_we_o     <= we_nxt;
      wb.wb_adr_o    <= adr_nxt;
      wb.wb_dat_o    <= dat_nxt;
      wb.wb_sel_o    <= sel_nxt;
      rdata_o        <= rdata_nxt;
      rdata_valid_o  <= valid_nxt;
      access_fault_o <= fault_nxt;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_stall_master.sv
// Directed bench for mem_bus_stall_master: load, store, error, ack+err, held request,
// mid-access reset and the no-ack case (abort with MEM_TIMEOUT_EN, endless stall without).
module tb_mem_bus_stall_master;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [3:0]        mem_sel_i;
  logic              stallreq_o;
  logic [DATA_W-1:0] rdata_o;
  logic              rdata_valid_o;
  logic              access_fault_o;

  int n_chk;
  int n_err;
  int stall_cnt;

  mem_bus_stall_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_stall_master #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_i     (mem_req_i),
    .mem_we_i      (mem_we_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_sel_i     (mem_sel_i),
    .stallreq_o    (stallreq_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .access_fault_o(access_fault_o),
    .wb            (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leave 1 ns after the rising edge: inputs change here, outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    mem_addr_i = '0;
    mem_wdata_i = '0;
    mem_sel_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;

    // Reset values
    #3;
    chk("rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("rst_stb", 32'(bus.wb_stb_o), 32'h0);
    chk("rst_we", 32'(bus.wb_we_o), 32'h0);
    chk("rst_adr", bus.wb_adr_o, 32'h0);
    chk("rst_sel", 32'(bus.wb_sel_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_valid", 32'(rdata_valid_o), 32'h0);
    chk("rst_fault", 32'(access_fault_o), 32'h0);
    chk("rst_stall", 32'(stallreq_o), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Load, ack on 3rd BUS cycle: 4 stall cycles
    stall_cnt = 0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h1000_0004; mem_sel_i = 4'hF;
    #1;
    chk("ld_idle_stall", 32'(stallreq_o), 32'h1);
    chk("ld_idle_cyc", 32'(bus.wb_cyc_o), 32'h0);
    stall_cnt += int'(stallreq_o);
    tick(); #1;
    chk("ld_bus1_cyc", 32'(bus.wb_cyc_o), 32'h1);
    chk("ld_bus1_stb", 32'(bus.wb_stb_o), 32'h1);
    chk("ld_bus1_we", 32'(bus.wb_we_o), 32'h0);
    chk("ld_bus1_adr", bus.wb_adr_o, 32'h1000_0004);
    stall_cnt += int'(stallreq_o);
    tick(); #1;
    stall_cnt += int'(stallreq_o);
    tick();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hDEAD_BEEF;
    #1;
    stall_cnt += int'(stallreq_o);
    tick();
    bus.wb_ack_i = 1'b0; bus.wb_dat_i = 32'h0;
    #1;
    chk("ld_done_stall", 32'(stallreq_o), 32'h0);
    chk("ld_done_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("ld_done_stb", 32'(bus.wb_stb_o), 32'h0);
    chk("ld_done_valid", 32'(rdata_valid_o), 32'h1);
    chk("ld_done_fault", 32'(access_fault_o), 32'h0);
    chk("ld_done_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("ld_stall_cycles", 32'(stall_cnt), 32'd4);

    // Request held through DONE was ignored; a new request now starts a store
    tick();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h2000_0000;
    mem_wdata_i = 32'h1234_5678; mem_sel_i = 4'b0011;
    #1;
    chk("st_idle_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("st_idle_valid", 32'(rdata_valid_o), 32'h0);
    chk("st_idle_stall", 32'(stallreq_o), 32'h1);
    stall_cnt = int'(stallreq_o);
    tick();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hFFFF_FFFF;
    mem_addr_i = 32'hAAAA_AAAA; mem_wdata_i = 32'h5555_5555; mem_sel_i = 4'hC; mem_we_i = 1'b0;
    #1;
    chk("st_bus_cyc", 32'(bus.wb_cyc_o), 32'h1);
    chk("st_bus_we", 32'(bus.wb_we_o), 32'h1);
    chk("st_bus_adr", bus.wb_adr_o, 32'h2000_0000);
    chk("st_bus_dat", bus.wb_dat_o, 32'h1234_5678);
    chk("st_bus_sel", 32'(bus.wb_sel_o), 32'h3);
    stall_cnt += int'(stallreq_o);
    tick();
    bus.wb_ack_i = 1'b0;
    #1;
    chk("st_done_valid", 32'(rdata_valid_o), 32'h1);
    chk("st_done_fault", 32'(access_fault_o), 32'h0);
    chk("st_done_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("st_done_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("st_stall_cycles", 32'(stall_cnt), 32'd2);
    tick();
    mem_req_i = 1'b0;
    #1;
    chk("st_idle2_cyc", 32'(bus.wb_cyc_o), 32'h0);

    // Error in 2nd BUS cycle
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h3000_0008; mem_sel_i = 4'hF;
    tick();
    tick();
    bus.wb_err_i = 1'b1; bus.wb_dat_i = 32'hBAD0_BAD0;
    #1;
    chk("err_bus2_cyc", 32'(bus.wb_cyc_o), 32'h1);
    tick();
    bus.wb_err_i = 1'b0;
    #1;
    chk("err_done_valid", 32'(rdata_valid_o), 32'h1);
    chk("err_done_fault", 32'(access_fault_o), 32'h1);
    chk("err_done_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("err_done_rdata", rdata_o, 32'hDEAD_BEEF);
    tick();
    mem_req_i = 1'b0;
    #1;
    chk("err_idle_fault", 32'(access_fault_o), 32'h0);
    chk("err_idle_valid", 32'(rdata_valid_o), 32'h0);

    // ack and err together behave as an error
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h3000_000C;
    tick();
    bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_dat_i = 32'h0101_0101;
    tick();
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
    #1;
    chk("both_fault", 32'(access_fault_o), 32'h1);
    chk("both_valid", 32'(rdata_valid_o), 32'h1);
    chk("both_rdata", rdata_o, 32'hDEAD_BEEF);
    tick();
    mem_req_i = 1'b0;

    // Reset in the middle of BUS
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h4000_0000;
    tick();
    tick();
    mem_req_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("mid_rst_stb", 32'(bus.wb_stb_o), 32'h0);
    chk("mid_rst_stall", 32'(stallreq_o), 32'h0);
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h7777_7777;
    tick();
    bus.wb_ack_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(rdata_valid_o), 32'h0);
    chk("mid_rst_rdata", rdata_o, 32'h0);
    tick();
    #1;
    chk("post_rst_valid", 32'(rdata_valid_o), 32'h0);
    chk("post_rst_cyc", 32'(bus.wb_cyc_o), 32'h0);
    mem_req_i = 1'b1; mem_addr_i = 32'h4000_0010;
    tick();
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h0BAD_F00D;
    #1;
    chk("post_rst_adr", bus.wb_adr_o, 32'h4000_0010);
    tick();
    bus.wb_ack_i = 1'b0;
    #1;
    chk("post_rst_ld_valid", 32'(rdata_valid_o), 32'h1);
    chk("post_rst_ld_rdata", rdata_o, 32'h0BAD_F00D);
    tick();
    mem_req_i = 1'b0;

    // Slave never answers
    mem_req_i = 1'b1; mem_addr_i = 32'h5000_0000;
    #1;
    stall_cnt = int'(stallreq_o);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 50; i++) begin
      tick(); #1;
      if (rdata_valid_o) break;
      stall_cnt += int'(stallreq_o);
    end
    chk("to_valid", 32'(rdata_valid_o), 32'h1);
    chk("to_fault", 32'(access_fault_o), 32'h1);
    chk("to_cyc", 32'(bus.wb_cyc_o), 32'h0);
    chk("to_stall_cycles", 32'(stall_cnt), 32'd9);
`else
    for (int i = 0; i < 120; i++) begin
      tick(); #1;
      stall_cnt += int'(stallreq_o & bus.wb_cyc_o);
    end
    chk("noto_stall_cycles", 32'(stall_cnt), 32'd121);
    chk("noto_valid", 32'(rdata_valid_o), 32'h0);
    bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'hCAFE_0001;
    tick();
    bus.wb_ack_i = 1'b0;
    #1;
    chk("noto_late_valid", 32'(rdata_valid_o), 32'h1);
    chk("noto_late_rdata", rdata_o, 32'hCAFE_0001);
`endif
    tick();
    mem_req_i = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_stall_master.md
Name: mem_bus_stall_master

Overview:
- Memory-stage load/store bus master; the requester side of the pipeline stall protocol.
- Converts a single-cycle load/store request from the MEM stage into a Wishbone-style classic bus cycle.
- Raises stallreq_o, which drives the controller's MEM stall input, for as long as the access is outstanding.
- Returns registered load data and an access-fault flag to MEM/WB.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte selects = DATA_W/8)
- TIMEOUT, 255, bus cycles without ack/err before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- mem_req_i  in  1  MEM stage holds a load/store this cycle
- mem_we_i  in  1  1=store, 0=load
- mem_addr_i  in  ADDR_W  access address
- mem_wdata_i  in  DATA_W  store data
- mem_sel_i  in  DATA_W/8  byte enables
- stallreq_o  out  1  stall request to ctrl (1=`Stop)
- rdata_o  out  DATA_W  registered load data
- rdata_valid_o  out  1  one-cycle pulse: access complete
- access_fault_o  out  1  one-cycle pulse with rdata_valid_o on err/timeout
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADDR_W  address
- wb_dat_o  out  DATA_W  write data
- wb_sel_o  out  DATA_W/8  byte selects
- wb_dat_i  in  DATA_W  read data
- wb_ack_i  in  1  slave acknowledge
- wb_err_i  in  1  slave error

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all wb_* outputs 0; rdata_o=0; rdata_valid_o=0; access_fault_o=0; timeout counter=0.
- stallreq_o is combinational: 1 when (state==IDLE and mem_req_i) or state==BUS; 0 otherwise. Asserting in IDLE is required so the pipeline freezes in the same cycle the request appears.
- IDLE:
  - On mem_req_i, register addr/wdata/sel/we onto the wb_* outputs.
  - Set cyc=stb=1 next cycle; go to BUS.
- BUS:
  - cyc/stb stay high; address, data, sel and we are held stable.
  - wb_ack_i=1: drop cyc/stb next edge. For a load, latch wb_dat_i into rdata_o (a store leaves rdata_o unchanged). Pulse rdata_valid_o. Go to DONE.
  - wb_err_i=1 (ack=0): same exit, but also pulse access_fault_o; rdata_o unchanged.
  - ack and err both high: treated as err.
- DONE:
  - Exactly one cycle; stallreq_o=0 so the pipeline advances past the instruction.
  - Go to IDLE unconditionally; mem_req_i is ignored here. The held request belongs to the instruction that is leaving the stage, so this prevents a duplicate access.
- Latency: request-to-release = 1 (issue) + N (ack wait, N>=1) cycles of stall; rdata_o is valid from the DONE cycle and held until the next completed load.
- rdata_valid_o and access_fault_o are high only in the cycle entering DONE (registered).
- mem_req_i dropping while in BUS has no effect; the bus cycle always completes.
- Reset mid-BUS: cyc/stb drop immediately (async) and no valid/fault pulse is generated.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entering BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT, the access aborts exactly like wb_err_i: cyc/stb drop, access_fault_o and rdata_valid_o pulse, state goes to DONE.
- Undefined: no counter; BUS waits for ack/err indefinitely.

Test Plan:
- Load, ack on the 3rd BUS cycle, wb_dat_i=0xDEADBEEF, addr 0x1000_0004 -> stallreq_o high 4 cycles; rdata_o=0xDEADBEEF; one rdata_valid_o pulse; access_fault_o=0.
- Store, addr 0x2000_0000, wdata 0x12345678, sel 4'b0011, ack in 1st BUS cycle -> wb_we_o=1 with stable adr/dat/sel while stb; rdata_o unchanged; stallreq_o high 2 cycles.
- wb_err_i in 2nd BUS cycle -> access_fault_o and rdata_valid_o pulse together; cyc low next cycle; rdata_o holds its previous value.
- mem_req_i held high through DONE -> exactly one bus cycle issued; a new request one cycle after DONE starts a second access.
- rst driven low mid-BUS, then released -> cyc/stb=0 immediately; state IDLE; no valid pulse; next request works normally.
- With MEM_TIMEOUT_EN, TIMEOUT=8, no ack -> abort after 8 BUS cycles with access_fault_o=1; without the macro, stallreq_o stays high for 100+ cycles.
